// File: rtl/riscv_pkg.sv
// Shared widths, ALU operation codes and the operand-slot record used by the
// ID/EX issue stage.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] ALU_ADD = 4'd0;
  localparam logic [SEL_W-1:0] ALU_SLL = 4'd1;
  localparam logic [SEL_W-1:0] ALU_SLT = 4'd2;
  localparam logic [SEL_W-1:0] ALU_XOR = 4'd4;
  localparam logic [SEL_W-1:0] ALU_SRL = 4'd5;
  localparam logic [SEL_W-1:0] ALU_OR  = 4'd6;
  localparam logic [SEL_W-1:0] ALU_AND = 4'd7;
  localparam logic [SEL_W-1:0] ALU_SUB = 4'd8;
  localparam logic [SEL_W-1:0] ALU_SRA = 4'd13;
  localparam logic [SEL_W-1:0] ALU_MUL = 4'd15;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic              use_imm;
    logic [SEL_W-1:0]  alusel;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
  } slot_t;

  // Overwrite any operand whose source register is being written back now.
  // x0 is never forwarded; immediate operands are never forwarded.
  function automatic slot_t apply_fwd(input slot_t s, input logic we,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [XLEN-1:0] data);
    slot_t r;
    r = s;
    if (we && (rd != '0)) begin
      if (r.rs1_addr == rd) r.rs1_val = data;
      if (!r.use_imm && (r.rs2_addr == rd)) r.rs2_val = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/operand_slot.sv
// One buffered instruction entry. Either loads a new record or keeps its own,
// and in both cases applies the current writeback forward before storing.
module operand_slot
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  slot_t             load_data,
  input  logic              kill,
  input  logic              fwd_we,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [XLEN-1:0]   fwd_data,
  output slot_t             q
);

  slot_t src;
  slot_t nxt;

  always_comb begin
    src = load ? load_data : q;
    nxt = apply_fwd(src, fwd_we, fwd_rd, fwd_data);
    // Invalidation wins over any load; data is left as-is.
    if (kill) nxt.valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand issue stage: two-entry skid buffer (main + skid slot) with
// writeback forwarding; ALU operands come straight from the main slot.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic              in_use_imm,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [SEL_W-1:0]  in_alusel,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_rd_we,
  input  logic              fwd_we,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [XLEN-1:0]   fwd_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   RS1,
  output logic [XLEN-1:0]   RS2,
  output logic [SEL_W-1:0]  ALUsel,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_rd_we,
  output logic [1:0]        occupancy
);

  import riscv_pkg::*;

  slot_t main_q, skid_q, in_beat, main_d;
  logic  accept, drain, main_take;
  logic  main_load, main_kill, skid_load, skid_kill;

  // Skid valid is a register, so in_ready never sees out_ready combinationally.
  assign in_ready  = !skid_q.valid;
  assign accept    = in_valid & in_ready;
  assign drain     = main_q.valid & out_ready;
  assign main_take = !main_q.valid | drain;

  always_comb begin
    in_beat          = '0;
    in_beat.valid    = 1'b1;
    in_beat.rs1_addr = in_rs1_addr;
    in_beat.rs2_addr = in_rs2_addr;
    in_beat.rs1_val  = in_rs1_data;
    in_beat.rs2_val  = in_use_imm ? in_imm : in_rs2_data;
    in_beat.use_imm  = in_use_imm;
    in_beat.alusel   = in_alusel;
    in_beat.rd       = in_rd_addr;
    in_beat.rd_we    = in_rd_we;
  end

  always_comb begin
    main_load = 1'b0;
    main_kill = flush;
    main_d    = in_beat;
    skid_load = 1'b0;
    skid_kill = flush;
    if (main_take) begin
      if (skid_q.valid) begin
        main_load = 1'b1;
        main_d    = skid_q;
        skid_load = accept;
        skid_kill = flush | !accept;
      end else begin
        main_load = accept;
        main_kill = flush | !accept;
      end
    end else begin
      skid_load = accept;
    end
  end

  operand_slot u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (main_load),
    .load_data (main_d),
    .kill      (main_kill),
    .fwd_we    (fwd_we),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .q         (main_q)
  );

  operand_slot u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .load_data (in_beat),
    .kill      (skid_kill),
    .fwd_we    (fwd_we),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .q         (skid_q)
  );

  assign out_valid   = main_q.valid;
  assign RS1         = main_q.rs1_val;
  assign RS2         = main_q.rs2_val;
  assign ALUsel      = main_q.alusel;
  assign out_rd_addr = main_q.rd;
  assign out_rd_we   = main_q.rd_we;
  assign occupancy   = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the stage.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm, in_rd_we;
  logic [3:0]  in_alusel;
  logic        fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] RS1, RS2;
  logic [3:0]  ALUsel;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_alusel(in_alusel),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .RS1(RS1), .RS2(RS2),
    .ALUsel(ALUsel), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
    .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of at most two pending instructions.
  typedef struct {
    logic [4:0]  a1, a2;
    logic [31:0] v1, v2;
    logic        imm;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  ent_t mq[$];

  function automatic ent_t fwd(input ent_t e);
    ent_t r;
    r = e;
    if (fwd_we && fwd_rd != 5'd0) begin
      if (r.a1 == fwd_rd) r.v1 = fwd_data;
      if (!r.imm && r.a2 == fwd_rd) r.v2 = fwd_data;
    end
    return r;
  endfunction

  function automatic ent_t capture();
    ent_t e;
    e.a1  = in_rs1_addr;
    e.a2  = in_rs2_addr;
    e.v1  = in_rs1_data;
    e.v2  = in_use_imm ? in_imm : in_rs2_data;
    e.imm = in_use_imm;
    e.sel = in_alusel;
    e.rd  = in_rd_addr;
    e.we  = in_rd_we;
    return fwd(e);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit acc, drn;
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < 2);
      drn = out_ready && (mq.size() > 0);
      foreach (mq[i]) mq[i] = fwd(mq[i]);
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(capture());
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("occupancy", {30'd0, occupancy}, mq.size());
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    if (mq.size() > 0) begin
      chk("RS1", RS1, mq[0].v1);
      chk("RS2", RS2, mq[0].v2);
      chk("ALUsel", {28'd0, ALUsel}, {28'd0, mq[0].sel});
      chk("rd_addr", {27'd0, out_rd_addr}, {27'd0, mq[0].rd});
      chk("rd_we", {31'd0, out_rd_we}, {31'd0, mq[0].we});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] a2, input logic [31:0] d2,
                      input logic [3:0] sel);
    in_valid    = 1'b1;
    in_rs1_addr = a1;
    in_rs1_data = d1;
    in_rs2_addr = a2;
    in_rs2_data = d2;
    in_use_imm  = 1'b0;
    in_imm      = 32'd0;
    in_alusel   = sel;
    in_rd_addr  = 5'd10;
    in_rd_we    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0;
    in_rs2_data = 0; in_use_imm = 0; in_imm = 0; in_alusel = 0;
    in_rd_addr = 0; in_rd_we = 0; fwd_we = 0; fwd_rd = 0; fwd_data = 0;
    flush = 0; out_ready = 0;
    #12;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst RS1", RS1, 32'd0);
    chk("rst RS2", RS2, 32'd0);
    chk("rst ALUsel", {28'd0, ALUsel}, 32'd0);
    chk("rst rd", {26'd0, out_rd_we, out_rd_addr}, 32'd0);
    chk("rst occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Single beat, one-cycle latency.
    out_ready = 1'b1;
    beat(5'd1, 32'd5, 5'd2, 32'd7, 4'd0);
    step();
    in_valid = 1'b0;
    chk("t1 out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1 RS1", RS1, 32'd5);
    chk("t1 RS2", RS2, 32'd7);
    chk("t1 occ", {30'd0, occupancy}, 32'd1);
    step();
    chk("t1 drained", {31'd0, out_valid}, 32'd0);

    // Back-to-back under stall, then release.
    out_ready = 1'b0;
    beat(5'd1, 32'd11, 5'd2, 32'd0, 4'd8);
    step();
    beat(5'd1, 32'd22, 5'd2, 32'd0, 4'd4);
    step();
    chk("t2 in_ready full", {31'd0, in_ready}, 32'd0);
    beat(5'd1, 32'd33, 5'd2, 32'd0, 4'd6);
    step();
    chk("t2 occ", {30'd0, occupancy}, 32'd2);
    chk("t2 beat1", RS1, 32'd11);
    out_ready = 1'b1;
    step();
    chk("t2 beat2", RS1, 32'd22);
    step();
    in_valid = 1'b0;
    chk("t2 beat3", RS1, 32'd33);
    chk("t2 sel3", {28'd0, ALUsel}, 32'd6);
    step();
    chk("t2 empty", {30'd0, occupancy}, 32'd0);

    // Forward into a held beat.
    out_ready = 1'b0;
    beat(5'd3, 32'd100, 5'd2, 32'd0, 4'd0);
    step();
    in_valid = 1'b0;
    chk("t3 held", RS1, 32'd100);
    step();
    fwd_we = 1'b1; fwd_rd = 5'd3; fwd_data = 32'hDEADBEEF;
    step();
    fwd_we = 1'b0;
    chk("t3 fwd held", RS1, 32'hDEADBEEF);
    out_ready = 1'b1;
    step();

    // Immediate operand is never forwarded; x0 never forwarded.
    beat(5'd6, 32'd1, 5'd4, 32'd55, 4'd0);
    in_use_imm = 1'b1; in_imm = 32'hFFFFFFF0;
    fwd_we = 1'b1; fwd_rd = 5'd4; fwd_data = 32'd1234;
    step();
    chk("t4 imm", RS2, 32'hFFFFFFF0);
    beat(5'd0, 32'd0, 5'd2, 32'd3, 4'd0);
    fwd_rd = 5'd0; fwd_data = 32'd9;
    step();
    chk("t4 x0", RS1, 32'd0);
    beat(5'd5, 32'd1, 5'd2, 32'd3, 4'd0);
    fwd_rd = 5'd5; fwd_data = 32'd77;
    step();
    in_valid = 1'b0; fwd_we = 1'b0;
    chk("t4 capture fwd", RS1, 32'd77);
    step();

    // Flush with full buffer, and flush racing an accept.
    out_ready = 1'b0;
    beat(5'd1, 32'd1, 5'd2, 32'd2, 4'd0);
    step();
    step();
    chk("t5 occ2", {30'd0, occupancy}, 32'd2);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5 valid", {31'd0, out_valid}, 32'd0);
    chk("t5 occ", {30'd0, occupancy}, 32'd0);
    chk("t5 in_ready", {31'd0, in_ready}, 32'd1);
    beat(5'd1, 32'hAA, 5'd2, 32'd2, 4'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("t5 beat dropped", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream.
    beat(5'd1, 32'h12, 5'd2, 32'h34, 4'd7);
    step();
    step();
    in_valid = 1'b0;
    chk("t6 occ2", {30'd0, occupancy}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 async valid", {31'd0, out_valid}, 32'd0);
    chk("t6 async RS1", RS1, 32'd0);
    chk("t6 async ALUsel", {28'd0, ALUsel}, 32'd0);
    chk("t6 async occ", {30'd0, occupancy}, 32'd0);
    chk("t6 async in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst_n = 1'b1;
    step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_rs1_addr = 5'($urandom_range(0, 7));
      in_rs2_addr = 5'($urandom_range(0, 7));
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_use_imm  = $urandom_range(0, 1) == 1;
      in_imm      = $urandom;
      in_alusel   = 4'($urandom);
      in_rd_addr  = 5'($urandom);
      in_rd_we    = $urandom_range(0, 1) == 1;
      fwd_we      = $urandom_range(0, 1) == 1;
      fwd_rd      = 5'($urandom_range(0, 7));
      fwd_data    = $urandom;
      flush       = ($urandom_range(0, 31) == 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; fwd_we = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Registered issue stage between decode/register-file read and the ALU.
- Captures decoded operands and the ALU select code, and resolves writeback-to-operand hazards by forwarding.
- Buffers up to two instructions with a valid/ready skid so ALU-side stalls never drop a beat.
- Drives the ALU operand inputs RS1/RS2/ALUsel directly from registers.

Parameters:
- XLEN, 32, operand/data width.
- REG_AW, 5, register address width (x0..x31).
- SEL_W, 4, ALU select width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode beat present.
- in_ready  out  1  stage can accept a beat.
- in_rs1_addr  in  REG_AW  source register 1 index.
- in_rs2_addr  in  REG_AW  source register 2 index.
- in_rs1_data  in  XLEN  register-file read data 1.
- in_rs2_data  in  XLEN  register-file read data 2.
- in_use_imm  in  1  RS2 taken from in_imm.
- in_imm  in  XLEN  sign-extended immediate.
- in_alusel  in  SEL_W  ALU operation code.
- in_rd_addr  in  REG_AW  destination register.
- in_rd_we  in  1  destination write enable.
- fwd_we  in  1  writeback write this cycle.
- fwd_rd  in  REG_AW  writeback destination.
- fwd_data  in  XLEN  writeback value.
- flush  in  1  discard all held beats (branch redirect).
- out_valid  out  1  RS1/RS2/ALUsel hold a valid beat.
- out_ready  in  1  ALU/EX-MEM consumes the beat.
- RS1  out  XLEN  ALU operand 1.
- RS2  out  XLEN  ALU operand 2 (register or immediate).
- ALUsel  out  SEL_W  ALU operation code.
- out_rd_addr  out  REG_AW  destination, travels with the beat.
- out_rd_we  out  1  destination write enable.
- occupancy  out  2  held beats, 0..2.

Behaviour:
- Storage:
  - Main slot drives the outputs; skid slot sits behind it.
  - Each slot holds rs1/rs2 addresses, rs1 value, rs2 value, use_imm, alusel, rd, rd_we and valid.
- Reset (async, rst_n=0):
  - Both valids 0; all data fields 0.
  - out_valid=0, RS1=RS2=0, ALUsel=0, out_rd_addr=0, out_rd_we=0, occupancy=0, in_ready=1.
- in_ready = !skid_valid, registered; it never depends combinationally on out_ready.
- Transfer rules:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- Next-state (no flush):
  - Main empty or draining, skid valid: skid moves to main; an accepted beat goes to skid.
  - Main empty or draining, skid empty: an accepted beat goes to main.
  - Main full and not draining: an accepted beat goes to skid.
- Latency and throughput:
  - Input to out_valid: 1 cycle when empty.
  - Sustained throughput: 1 beat/cycle while out_ready=1.
  - Order is strictly FIFO.
- Forwarding at capture:
  - When fwd_we=1, fwd_rd!=0 and fwd_rd==in_rs1_addr, store fwd_data instead of in_rs1_data.
  - Same rule for rs2 when in_use_imm=0.
  - When in_use_imm=1, the rs2 value is in_imm and is never forwarded.
- Forwarding while held:
  - Every cycle, any valid slot whose rs1 (or non-imm rs2) address equals a nonzero fwd_rd with fwd_we=1 overwrites that operand with fwd_data.
  - This also applies in the same cycle the slot moves from skid to main.
- x0 rules: fwd_rd=0 never forwards; an rs address of 0 keeps the captured value.
- flush (synchronous):
  - Clears both valids next edge; a beat accepted in the same cycle is discarded.
  - Data fields need not be cleared.
  - Flush takes priority over accept and drain.
- Output value rule: outputs always reflect the main slot's fields. When out_valid=0 their values are don't-care except after reset (0).
- occupancy = main_valid + skid_valid.
- Reset asserted mid-operation drops all beats immediately, asynchronously.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN, REG_AW, SEL_W.
  - ALU op constants: ADD=0, SLL=1, SLT=2, XOR=4, SRL=5, OR=6, AND=7, SUB=8, SRA=13, MUL=15.
  - Operand-slot struct typedef.
- Sub-module operand_slot: one entry holding the fields plus its per-cycle forwarding update logic. It is instantiated twice (main, skid); the top level contains only the load/select control.

Test Plan:
- Reset, then in: rs1=x1 data 5, rs2=x2 data 7, alusel=0 (ADD), out_ready=1 -> next cycle out_valid=1, RS1=5, RS2=7, ALUsel=0, occupancy=1.
- out_ready=0 with 3 back-to-back beats -> beats 1 and 2 held, in_ready=0 after beat 2, beat 3 stalls. Release out_ready -> outputs beats 1, 2, 3 in order, none lost.
- Held beat rs1=x3 stalled 2 cycles, fwd_we=1, fwd_rd=3, fwd_data=0xDEADBEEF -> RS1 becomes 0xDEADBEEF the next cycle.
- Capture with in_use_imm=1, in_imm=0xFFFFFFF0, rs2=x4, same-cycle forward to x4 -> RS2=0xFFFFFFF0. Capture with rs1=x0, fwd_rd=0, fwd_data=9 -> RS1 keeps in_rs1_data=0.
- occupancy=2 and flush=1 together with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, and the input beat is not seen.
- rst_n pulsed low mid-stream with occupancy=2 -> outputs 0 and out_valid=0 immediately, without waiting for a clock edge.
